// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  // Parity bit for a data byte; odd=1 flips even parity into odd parity.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last cycle of a bit, tick_pre the cycle before it.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_pre
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             pre_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Flags are registered against the next count so they line up with cnt_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      pre_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);
      pre_q  <= (cnt_d == CNT_PRE);
    end
  end

  assign tick     = tick_q;
  assign tick_pre = pre_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: one pop per frame, start bit,
// 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);
  localparam logic TWO_STOPS  = (STOP_BITS > 1);

  tx_state_t            state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  logic                 stop_idx_q;
  logic                 tx_q;
  logic                 rd_en_q;
  logic                 busy_q;
  logic                 done_q;

  logic tick;
  logic tick_pre;
  logic baud_clear;
  logic last_stop;

  assign baud_clear = (state_q == LOAD);
  assign last_stop  = !TWO_STOPS || stop_idx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  // Frame sequencer; tx/rd_en/busy/done are set one edge ahead of their cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= LINE_IDLE;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q <= LINE_IDLE;
          if (!fifo_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          shift_q    <= fifo_data;
          parity_q   <= parity_of(fifo_data, ODD_PARITY);
          bit_idx_q  <= '0;
          stop_idx_q <= 1'b0;
          tx_q       <= LINE_START;
          state_q    <= START;
        end
        START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == LAST_BIT) begin
              if (HAS_PARITY) begin
                tx_q    <= parity_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= LINE_STOP;
                state_q <= STOP;
              end
            end else begin
              tx_q      <= shift_q[1];
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx_q    <= LINE_STOP;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick_pre && last_stop) begin
            done_q <= 1'b1;
          end
          if (tick) begin
            if (!last_stop) begin
              stop_idx_q <= 1'b1;
            end else if (!fifo_empty) begin
              state_q <= FETCH;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitters (plain 8N1 and 8O2, both 4 clocks/bit) fed from bench FIFOs
// and checked cycle by cycle against a frame-level expected-output queue.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam logic [3:0] EXP_IDLE  = 4'b1000;  // {tx, rd_en, busy, done}
  localparam logic [3:0] EXP_FETCH = 4'b1110;
  localparam logic [3:0] EXP_LOAD  = 4'b1010;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] fe = 2'b11;
  logic [1:0][7:0] fd = '0;
  logic [1:0] rd, txo, bsy, dn;
  logic glitch_en = 1'b0;
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;
  int rd_cnt [2] = '{0, 0};
  int dn_cnt [2] = '{0, 0};

  logic [7:0] fq0 [$];
  logic [7:0] fq1 [$];
  logic [3:0] mq0 [$];
  logic [3:0] mq1 [$];
  logic [3:0] cur [2];
  logic s_tx [2][64];
  logic s_rd [2][64];
  logic s_dn [2][64];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .reset(reset), .fifo_empty(fe[0]), .fifo_data(fd[0]),
    .fifo_rd_en(rd[0]), .tx(txo[0]), .busy(bsy[0]), .frame_done(dn[0])
  );

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) dut1 (
    .clk(clk), .reset(reset), .fifo_empty(fe[1]), .fifo_data(fd[1]),
    .fifo_rd_en(rd[1]), .tx(txo[1]), .busy(bsy[1]), .frame_done(dn[1])
  );

  function automatic void check(input string name, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endfunction

  function automatic void fifo_push(input int i, input logic [7:0] b);
    if (i == 0) fq0.push_back(b);
    else fq1.push_back(b);
  endfunction

  function automatic int fifo_size(input int i);
    return (i == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic logic [7:0] fifo_pop(input int i);
    if (i == 0) return fq0.pop_front();
    return fq1.pop_front();
  endfunction

  function automatic logic [7:0] fifo_front(input int i);
    if (fifo_size(i) == 0) return 8'h00;
    return (i == 0) ? fq0[0] : fq1[0];
  endfunction

  function automatic void exp_push(input int i, input logic [3:0] v);
    if (i == 0) mq0.push_back(v);
    else mq1.push_back(v);
  endfunction

  function automatic int exp_size(input int i);
    return (i == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [3:0] exp_pop(input int i);
    if (i == 0) return mq0.pop_front();
    return mq1.pop_front();
  endfunction

  // Whole-frame expected outputs: fetch, load, then each line level held CPB cycles.
  function automatic void add_frame(input int i, input logic [7:0] b);
    logic [11:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int k = 0; k < 8; k++) begin
      bits[n] = b[k];
      n++;
    end
    if (i == 1) begin
      bits[n] = ~(^b);
      n++;
    end
    for (int s = 0; s < ((i == 1) ? 2 : 1); s++) begin
      bits[n] = 1'b1;
      n++;
    end
    exp_push(i, EXP_FETCH);
    exp_push(i, EXP_LOAD);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CPB; c++) begin
        exp_push(i, {bits[k], 1'b0, 1'b1, 1'((k == n - 1) && (c == CPB - 1))});
      end
    end
  endfunction

  // Reference model: decides each cycle's expected outputs at the clock edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq0.delete();
      mq1.delete();
      cur[0] = EXP_IDLE;
      cur[1] = EXP_IDLE;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (chk_en) check((i == 0) ? "pop_while_empty0" : "pop_while_empty1", 32'(rd[i] & fe[i]), 0);
        if (exp_size(i) == 0 && !fe[i]) add_frame(i, fifo_front(i));
        cur[i] = (exp_size(i) != 0) ? exp_pop(i) : EXP_IDLE;
      end
    end
  end

  // Output compare, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check((i == 0) ? "outputs0" : "outputs1", 32'({txo[i], rd[i], bsy[i], dn[i]}), 32'(cur[i]));
        if (rd[i]) rd_cnt[i]++;
        if (dn[i]) dn_cnt[i]++;
      end
    end
  end

  // Bench FIFO: read data appears after a pop; empty may glitch mid-frame on request.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i]) begin
        if (fifo_size(i) != 0) fd[i] = fifo_pop(i);
      end else if (fifo_size(i) != 0) begin
        fe[i] = 1'b0;
      end else if (glitch_en && exp_size(i) > 12) begin
        fe[i] = 1'($urandom_range(0, 1));
      end else begin
        fe[i] = 1'b1;
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (!(exp_size(0) == 0 && exp_size(1) == 0 && fifo_size(0) == 0 && fifo_size(1) == 0 &&
             cur[0] == EXP_IDLE && cur[1] == EXP_IDLE) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic analyse(input int i, input int nbits, input logic [11:0] exp_bits, input int exp_done);
    int fi, st, di, nrd, ndn;
    logic [11:0] got;
    logic stable;
    fi = -1;
    di = -1;
    nrd = 0;
    ndn = 0;
    for (int k = 0; k < 64; k++) begin
      if (s_rd[i][k] && fi < 0) fi = k;
      if (s_rd[i][k]) nrd++;
      if (s_dn[i][k]) ndn++;
    end
    check("lit_fetch_seen", 32'(fi >= 0 && fi <= 14), 1);
    if (fi < 0 || fi > 14) return;
    st = fi + 2;
    got = '0;
    stable = 1'b1;
    for (int b = 0; b < nbits; b++) begin
      got[b] = s_tx[i][st + 4 * b];
      for (int c = 0; c < CPB; c++) begin
        if (s_tx[i][st + 4 * b + c] !== got[b]) stable = 1'b0;
      end
    end
    for (int k = st; k < 64; k++) begin
      if (s_dn[i][k] && di < 0) di = k;
    end
    check("lit_gap_high", 32'({s_tx[i][fi], s_tx[i][fi + 1]}), 3);
    check("lit_frame_bits", 32'(got), 32'(exp_bits));
    check("lit_bit_stable", 32'(stable), 1);
    check("lit_done_cycle", 32'(di - st), 32'(exp_done));
    check("lit_rd_pulses", 32'(nrd), 1);
    check("lit_done_pulses", 32'(ndn), 1);
  endtask

  initial begin
    int r0, r1, d0, d1, n;
    logic [7:0] b0;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset with an empty FIFO.
    repeat (100) @(negedge clk);
    check("idle_tx", 32'(txo), 3);
    check("idle_busy", 32'(bsy), 0);
    check("idle_rd", 32'(rd), 0);
    check("idle_no_pops", 32'(rd_cnt[0] + rd_cnt[1]), 0);

    // Single frames with hand-computed line levels.
    fifo_push(0, 8'hA5);
    fifo_push(1, 8'h07);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        s_tx[i][k] = txo[i];
        s_rd[i][k] = rd[i];
        s_dn[i][k] = dn[i];
      end
    end
    analyse(0, 10, 12'b00_1101001010, 39);
    analyse(1, 12, 12'b1100_0000_1110, 47);
    drain("single");

    // Back-to-back frames.
    r0 = rd_cnt[0]; r1 = rd_cnt[1]; d0 = dn_cnt[0]; d1 = dn_cnt[1];
    for (int i = 0; i < 2; i++) begin
      fifo_push(i, 8'h00);
      fifo_push(i, 8'hFF);
      fifo_push(i, 8'h3C);
    end
    drain("b2b");
    check("b2b_rd0", 32'(rd_cnt[0] - r0), 3);
    check("b2b_rd1", 32'(rd_cnt[1] - r1), 3);
    check("b2b_done0", 32'(dn_cnt[0] - d0), 3);
    check("b2b_done1", 32'(dn_cnt[1] - d1), 3);
    check("b2b_idle_busy", 32'(bsy), 0);

    // Random bytes at random times.
    for (int k = 0; k < 30; k++) begin
      n = $urandom_range(1, 3);
      if (n[0]) fifo_push(0, 8'($urandom));
      if (n[1]) fifo_push(1, 8'($urandom));
      repeat ($urandom_range(0, 70)) @(negedge clk);
    end
    drain("random");

    // Reset in the middle of data bit 3.
    b0 = 8'($urandom);
    fifo_push(0, b0);
    fifo_push(1, 8'($urandom));
    n = 0;
    while (!cur[0][2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_fetch_seen", 32'(n < 20), 1);
    repeat (19) @(negedge clk);
    check("mid_bit3_level", 32'(txo[0]), 32'(b0[3]));
    #1 reset = 1'b0;
    #1;
    check("mid_async_tx", 32'(txo), 3);
    check("mid_async_busy", 32'(bsy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    repeat (30) @(negedge clk);
    check("post_reset_no_pop", 32'((rd_cnt[0] - r0) + (rd_cnt[1] - r1)), 0);
    fifo_push(0, 8'($urandom));
    fifo_push(1, 8'($urandom));
    drain("post_reset");
    check("post_reset_rd0", 32'(rd_cnt[0] - r0), 1);
    check("post_reset_rd1", 32'(rd_cnt[1] - r1), 1);

    // Empty flag toggling while a frame is in flight.
    r0 = rd_cnt[0]; r1 = rd_cnt[1];
    glitch_en = 1'b1;
    fifo_push(0, 8'($urandom));
    fifo_push(1, 8'($urandom));
    drain("glitch");
    glitch_en = 1'b0;
    check("glitch_rd0", 32'(rd_cnt[0] - r0), 1);
    check("glitch_rd1", 32'(rd_cnt[1] - r1), 1);
    check("glitch_idle_busy", 32'(bsy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
